// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// ============================================================================
// uart_tx_fifo
// ----------------------------------------------------------------------------
// UART transmitter with an internal transmit FIFO. Producers queue words
// through a valid/ready handshake. Each word goes out LSB first as a frame:
// start bit (0), DATA_BITS data bits, an optional parity bit, and STOP_BITS
// stop bits (1). Queued frames are sent back to back with no idle gap.
//
// Build option:
//    UART_TX_PARITY_EN  when defined, a parity bit follows the data bits.
//                       It is even parity, or odd parity when PARITY_ODD=1.
//                       When undefined, there is no parity state or logic.
//
// Parameters:
//    CLK_FRE     clock frequency in MHz
//    BAUD_RATE   serial baud rate; CYCLE = CLK_FRE*1e6/BAUD_RATE clocks/bit
//    DATA_BITS   data bits per frame (5..9)
//    STOP_BITS   stop bits per frame (1 or 2)
//    FIFO_DEPTH  FIFO entries (power of two, >= 2)
//    PARITY_ODD  0 = even, 1 = odd (only with UART_TX_PARITY_EN)
//
// Ports:
//    clk            in   clock, rising edge
//    rst_n          in   asynchronous active-low reset
//    tx_data        in   word to queue
//    tx_data_valid  in   tx_data is valid
//    tx_data_ready  out  FIFO not full; a push happens on valid && ready
//    tx_pin         out  registered serial output, idles high
//    tx_busy        out  FSM not idle or FIFO non-empty
//    fifo_count     out  queued words, not counting the frame in flight
// ============================================================================
module uart_tx_fifo #(
   parameter int CLK_FRE    = 50,
   parameter int BAUD_RATE  = 115200,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16,
   parameter int PARITY_ODD = 0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DATA_BITS-1:0]          tx_data,
   input  logic                          tx_data_valid,
   output logic                          tx_data_ready,
   output logic                          tx_pin,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CW    = AW + 1;
   localparam int BW    = $clog2(DATA_BITS);

   // PARITY_ODD takes only the values 0 and 1; any other value selects
   // this marker block, which is visible in the elaborated hierarchy.
   generate
      if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_parity_odd_out_of_range
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t                state;
   state_t                state_next;

   logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
   logic [AW:0]           wr_ptr;
   logic [AW:0]           rd_ptr;
   logic [CW-1:0]         count_next;
   logic                  empty;
   logic                  push;
   logic                  pop;

   logic [15:0]           cycle_cnt;
   logic [BW-1:0]         bit_cnt;
   logic                  stop_cnt;
   logic [DATA_BITS-1:0]  data_latch;
   logic                  bit_end;
   logic                  last_data;
   logic                  last_stop;

   // ------------------------------------------------------------------------
   // FIFO
   // ------------------------------------------------------------------------
   // Pointers carry one extra wrap bit, so equal pointers mean empty while
   // pointers differing only in the top bit mean full.
   assign empty = (wr_ptr == rd_ptr);
   assign push  = tx_data_valid && tx_data_ready;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= tx_data;
      end
   end

   always_comb begin
      count_next = fifo_count;
      case ({push, pop})
         2'b10:   count_next = fifo_count + 1'b1;
         2'b01:   count_next = fifo_count - 1'b1;
         default: count_next = fifo_count;
      endcase
   end

   // Ready is registered off the next count, so a pop on the same edge as a
   // full FIFO does not reopen the input until the following cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_count    <= '0;
         tx_data_ready <= 1'b1;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         fifo_count    <= count_next;
         tx_data_ready <= (count_next != CW'(FIFO_DEPTH));
      end
   end

   // ------------------------------------------------------------------------
   // Transmit FSM
   // ------------------------------------------------------------------------
   assign bit_end   = (cycle_cnt == 16'(CYCLE - 1));
   assign last_data = (bit_cnt == BW'(DATA_BITS - 1));
   assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Pops are decided from the FIFO state before the edge, so a word pushed
   // into an empty FIFO is not popped until the following edge.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               state_next = START;
            end
         end
         START: begin
            if (bit_end) begin
               state_next = DATA;
            end
         end
         DATA: begin
            if (bit_end && last_data) begin
`ifdef UART_TX_PARITY_EN
               state_next = PARITY;
`else
               state_next = STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               state_next = STOP;
            end
         end
`endif
         STOP: begin
            // Chaining straight into START keeps queued frames gap-free.
            if (bit_end && last_stop) begin
               if (!empty) begin
                  pop        = 1'b1;
                  state_next = START;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Bit timing and position counters. cycle_cnt restarts at each bit
   // boundary and stays cleared while idle, so the first bit after a pop
   // lasts a full CYCLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt  <= '0;
         bit_cnt    <= '0;
         stop_cnt   <= 1'b0;
         data_latch <= '0;
      end else begin
         if (state == IDLE || bit_end) begin
            cycle_cnt <= '0;
         end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
         end

         if (state != DATA) begin
            bit_cnt <= '0;
         end else if (bit_end) begin
            bit_cnt <= last_data ? '0 : bit_cnt + 1'b1;
         end

         if (state != STOP) begin
            stop_cnt <= 1'b0;
         end else if (bit_end) begin
            stop_cnt <= last_stop ? 1'b0 : stop_cnt + 1'b1;
         end

         if (pop) begin
            data_latch <= mem[rd_ptr[AW-1:0]];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Serial output
   // ------------------------------------------------------------------------
`ifdef UART_TX_PARITY_EN
   logic parity_bit;
   assign parity_bit = (^data_latch) ^ 1'(PARITY_ODD);
`endif

   // The pin is registered from the current state, so it trails the FSM by
   // one clock. Every bit still lasts exactly CYCLE clocks on the pin.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_pin <= 1'b1;
      end else begin
         case (state)
            START:   tx_pin <= 1'b0;
            DATA:    tx_pin <= data_latch[bit_cnt];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_pin <= parity_bit;
`endif
            default: tx_pin <= 1'b1;
         endcase
      end
   end

   assign tx_busy = (state != IDLE) || !empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
// ============================================================================
// tb_uart_tx_fifo
// ----------------------------------------------------------------------------
// Directed bench for uart_tx_fifo with CYCLE=10 (CLK_FRE=1, BAUD_RATE=100000).
// The main instance uses 8 data bits, 1 stop bit and a 4-entry FIFO. A second
// instance uses 5 data bits and 2 stop bits. With UART_TX_PARITY_EN defined,
// a third instance uses odd parity.
//
// step() advances one clock and records the selected instance's pin and busy
// one time unit after the edge. Log index 0 is the edge that accepted the
// first word of a scenario.
// ============================================================================
module tb_uart_tx_fifo;

   localparam int CYCLE   = 10;
   localparam int LOG_LEN = 1024;
`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int NB8    = 1 + 8 + PAR + 1;
   localparam int NB5    = 1 + 5 + PAR + 2;
   localparam int FRAME8 = CYCLE * NB8;
   localparam int FRAME5 = CYCLE * NB5;

   logic       clk;
   logic       rst_n;

   logic [7:0] tx_data;
   logic       tx_data_valid;
   logic       tx_data_ready;
   logic       tx_pin;
   logic       tx_busy;
   logic [2:0] fifo_count;

   logic [4:0] d5_data;
   logic       d5_valid;
   logic       d5_ready;
   logic       d5_pin;
   logic       d5_busy;
   logic [2:0] d5_count;

`ifdef UART_TX_PARITY_EN
   logic [7:0] do_data;
   logic       do_valid;
   logic       do_ready;
   logic       do_pin;
   logic       do_busy;
   logic [2:0] do_count;
`endif

   int         errors;
   int         checks;
   int         sel;
   int         log_n;
   logic       pin_log  [0:LOG_LEN-1];
   logic       busy_log [0:LOG_LEN-1];

   uart_tx_fifo #(
      .CLK_FRE(1), .BAUD_RATE(100000), .DATA_BITS(8), .STOP_BITS(1),
      .FIFO_DEPTH(4), .PARITY_ODD(0)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
      .tx_data_ready(tx_data_ready), .tx_pin(tx_pin), .tx_busy(tx_busy),
      .fifo_count(fifo_count)
   );

   uart_tx_fifo #(
      .CLK_FRE(1), .BAUD_RATE(100000), .DATA_BITS(5), .STOP_BITS(2),
      .FIFO_DEPTH(4), .PARITY_ODD(0)
   ) u_dut5 (
      .clk(clk), .rst_n(rst_n), .tx_data(d5_data), .tx_data_valid(d5_valid),
      .tx_data_ready(d5_ready), .tx_pin(d5_pin), .tx_busy(d5_busy),
      .fifo_count(d5_count)
   );

`ifdef UART_TX_PARITY_EN
   uart_tx_fifo #(
      .CLK_FRE(1), .BAUD_RATE(100000), .DATA_BITS(8), .STOP_BITS(1),
      .FIFO_DEPTH(4), .PARITY_ODD(1)
   ) u_dut_odd (
      .clk(clk), .rst_n(rst_n), .tx_data(do_data), .tx_data_valid(do_valid),
      .tx_data_ready(do_ready), .tx_pin(do_pin), .tx_busy(do_busy),
      .fifo_count(do_count)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock, then record the selected instance one time unit later.
   task automatic step();
      @(posedge clk);
      #1;
      if (log_n < LOG_LEN) begin
         case (sel)
            1: begin
               pin_log[log_n]  = d5_pin;
               busy_log[log_n] = d5_busy;
            end
`ifdef UART_TX_PARITY_EN
            2: begin
               pin_log[log_n]  = do_pin;
               busy_log[log_n] = do_busy;
            end
`endif
            default: begin
               pin_log[log_n]  = tx_pin;
               busy_log[log_n] = tx_busy;
            end
         endcase
      end
      log_n++;
   endtask

   // Expected level of frame bit j: start, data LSB first, parity, stops.
   function automatic logic exp_bit(input logic [8:0] d, input int nbits,
                                    input int odd, input int j);
      logic p;
      p = 1'b0;
      for (int i = 0; i < nbits; i++) p = p ^ d[i];
      if (j == 0) return 1'b0;
      if (j <= nbits) return d[j-1];
      if (PAR == 1 && j == nbits + 1) return p ^ odd[0];
      return 1'b1;
   endfunction

   function automatic int first_low_pin();
      for (int i = 0; i < log_n && i < LOG_LEN; i++) begin
         if (pin_log[i] === 1'b0) return i;
      end
      return -1;
   endfunction

   function automatic int first_low_busy();
      for (int i = 0; i < log_n && i < LOG_LEN; i++) begin
         if (busy_log[i] === 1'b0) return i;
      end
      return -1;
   endfunction

   // -------------------------------------------------------------------------
   task automatic test_reset();
      $display("[TB] test_reset");
      rst_n = 1'b1;
      tx_data = 8'h00; tx_data_valid = 1'b0;
      d5_data = 5'h00; d5_valid = 1'b0;
`ifdef UART_TX_PARITY_EN
      do_data = 8'h00; do_valid = 1'b0;
`endif
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (tx_pin !== 1'b1) begin errors++; $display("[TB] FAIL reset_pin: got %b expected 1", tx_pin); end
      checks++;
      if (tx_data_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", tx_data_ready); end
      checks++;
      if (tx_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", tx_busy); end
      checks++;
      if (fifo_count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", fifo_count); end
      checks++;
      if (d5_pin !== 1'b1 || d5_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL reset_d5: got pin=%b ready=%b expected 1 1", d5_pin, d5_ready);
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      sel = 0; log_n = 0;
      repeat (3) step();
      checks++;
      if (tx_pin !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== 3'd0) begin
         errors++;
         $display("[TB] FAIL reset_release: got pin=%b busy=%b count=%0d expected 1 0 0", tx_pin, tx_busy, fifo_count);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_single();
      int   fall, drop, bad;
      logic want, got;
      $display("[TB] test_single");
      sel = 0; log_n = 0;
      tx_data = 8'h55; tx_data_valid = 1'b1;
      step();
      tx_data_valid = 1'b0;
      checks++;
      if (fifo_count !== 3'd1) begin errors++; $display("[TB] FAIL single_count_push: got %0d expected 1", fifo_count); end
      repeat (FRAME8 + 18) step();

      fall = first_low_pin();
      checks++;
      if (fall !== 2) begin errors++; $display("[TB] FAIL single_fall: got index %0d expected 2", fall); end

      for (int b = 0; b < NB8; b++) begin
         want = exp_bit(9'h055, 8, 0, b);
         bad = 0; got = want;
         for (int k = 0; k < CYCLE; k++) begin
            if (pin_log[2 + b*CYCLE + k] !== want) begin bad = 1; got = pin_log[2 + b*CYCLE + k]; end
         end
         checks++;
         if (bad != 0) begin errors++; $display("[TB] FAIL single_bit%0d: got %b expected %b", b, got, want); end
      end

      checks++;
      if (pin_log[2 + FRAME8] !== 1'b1) begin errors++; $display("[TB] FAIL single_idle: got %b expected 1", pin_log[2 + FRAME8]); end
      checks++;
      if (busy_log[0] !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_on: got %b expected 1", busy_log[0]); end
      drop = first_low_busy();
      checks++;
      if (drop !== 1 + FRAME8) begin errors++; $display("[TB] FAIL single_busy_drop: got index %0d expected %0d", drop, 1 + FRAME8); end
      checks++;
      if (fifo_count !== 3'd0) begin errors++; $display("[TB] FAIL single_count_end: got %0d expected 0", fifo_count); end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_back_to_back();
      logic [7:0] words [2];
      int   fall, drop, bad;
      logic want, got;
      $display("[TB] test_back_to_back");
      words[0] = 8'hA3; words[1] = 8'h0F;
      sel = 0; log_n = 0;
      tx_data = 8'hA3; tx_data_valid = 1'b1;
      step();
      checks++;
      if (fifo_count !== 3'd1) begin errors++; $display("[TB] FAIL b2b_count_first: got %0d expected 1", fifo_count); end
      tx_data = 8'h0F;
      step();
      tx_data_valid = 1'b0;
      checks++;
      if (fifo_count !== 3'd1) begin errors++; $display("[TB] FAIL b2b_count_pushpop: got %0d expected 1", fifo_count); end
      repeat (2*FRAME8 + 16) step();

      fall = first_low_pin();
      checks++;
      if (fall !== 2) begin errors++; $display("[TB] FAIL b2b_fall: got index %0d expected 2", fall); end

      for (int w = 0; w < 2; w++) begin
         for (int b = 0; b < NB8; b++) begin
            want = exp_bit({1'b0, words[w]}, 8, 0, b);
            bad = 0; got = want;
            for (int k = 0; k < CYCLE; k++) begin
               if (pin_log[2 + w*FRAME8 + b*CYCLE + k] !== want) begin
                  bad = 1; got = pin_log[2 + w*FRAME8 + b*CYCLE + k];
               end
            end
            checks++;
            if (bad != 0) begin errors++; $display("[TB] FAIL b2b_w%0d_bit%0d: got %b expected %b", w, b, got, want); end
         end
      end

      checks++;
      if (pin_log[2 + 2*FRAME8] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_idle: got %b expected 1", pin_log[2 + 2*FRAME8]); end
      drop = first_low_busy();
      checks++;
      if (drop !== 1 + 2*FRAME8) begin errors++; $display("[TB] FAIL b2b_busy_drop: got index %0d expected %0d", drop, 1 + 2*FRAME8); end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_full();
      logic [7:0] words [6];
      int   bad, drop;
      logic want, got;
      $display("[TB] test_full");
      words[0] = 8'h81; words[1] = 8'h3C; words[2] = 8'hE7;
      words[3] = 8'h5A; words[4] = 8'hC3; words[5] = 8'h99;
      sel = 0; log_n = 0;
      tx_data_valid = 1'b1;
      // Words 0..4 are accepted: one goes into flight, four fill the FIFO.
      for (int i = 0; i < 5; i++) begin
         tx_data = words[i];
         step();
      end
      checks++;
      if (fifo_count !== 3'd4) begin errors++; $display("[TB] FAIL full_count: got %0d expected 4", fifo_count); end
      checks++;
      if (tx_data_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready: got %b expected 0", tx_data_ready); end
      tx_data = words[5];
      step();
      step();
      checks++;
      if (fifo_count !== 3'd4 || tx_data_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL full_refused: got count=%0d ready=%b expected 4 0", fifo_count, tx_data_ready);
      end
      tx_data_valid = 1'b0;
      repeat (5*FRAME8 + 20) step();

      for (int w = 0; w < 5; w++) begin
         bad = 0; got = 1'b0; want = 1'b0;
         for (int b = 0; b < NB8; b++) begin
            for (int k = 0; k < CYCLE; k++) begin
               if (bad == 0 && pin_log[2 + w*FRAME8 + b*CYCLE + k] !== exp_bit({1'b0, words[w]}, 8, 0, b)) begin
                  bad = 1;
                  got = pin_log[2 + w*FRAME8 + b*CYCLE + k];
                  want = exp_bit({1'b0, words[w]}, 8, 0, b);
               end
            end
         end
         checks++;
         if (bad != 0) begin errors++; $display("[TB] FAIL full_word%0d: got %b expected %b", w, got, want); end
      end

      bad = 0;
      for (int i = 2 + 5*FRAME8; i < log_n && i < LOG_LEN; i++) begin
         if (pin_log[i] !== 1'b1) bad = 1;
      end
      checks++;
      if (bad != 0) begin errors++; $display("[TB] FAIL full_no_extra: got 0 on pin expected 1"); end
      drop = first_low_busy();
      checks++;
      if (drop !== 1 + 5*FRAME8) begin errors++; $display("[TB] FAIL full_busy_drop: got index %0d expected %0d", drop, 1 + 5*FRAME8); end
      checks++;
      if (fifo_count !== 3'd0 || tx_data_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL full_end: got count=%0d ready=%b expected 0 1", fifo_count, tx_data_ready);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_reset_mid();
      int bad;
      $display("[TB] test_reset_mid");
      sel = 0; log_n = 0;
      tx_data_valid = 1'b1;
      tx_data = 8'hF0; step();
      tx_data = 8'h12; step();
      tx_data = 8'h34; step();
      tx_data_valid = 1'b0;
      checks++;
      if (fifo_count !== 3'd2) begin errors++; $display("[TB] FAIL mid_count_before: got %0d expected 2", fifo_count); end
      // Frame clock 35 sits in data bit 2 of 0xF0, which is 0.
      repeat (35) step();
      checks++;
      if (pin_log[37] !== 1'b0) begin errors++; $display("[TB] FAIL mid_pin_before: got %b expected 0", pin_log[37]); end

      rst_n = 1'b0;
      #1;
      checks++;
      if (tx_pin !== 1'b1) begin errors++; $display("[TB] FAIL mid_pin_reset: got %b expected 1", tx_pin); end
      checks++;
      if (fifo_count !== 3'd0) begin errors++; $display("[TB] FAIL mid_count_reset: got %0d expected 0", fifo_count); end
      checks++;
      if (tx_data_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_ready_reset: got %b expected 1", tx_data_ready); end
      checks++;
      if (tx_busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy_reset: got %b expected 0", tx_busy); end

      step();
      step();
      rst_n = 1'b1;
      log_n = 0;
      repeat (150) step();
      bad = 0;
      for (int i = 0; i < 150; i++) begin
         if (pin_log[i] !== 1'b1 || busy_log[i] !== 1'b0) bad = 1;
      end
      checks++;
      if (bad != 0) begin errors++; $display("[TB] FAIL mid_quiet_after: got activity expected idle pin=1 busy=0"); end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_dbits5();
      int   fall, drop, bad;
      logic want, got;
      $display("[TB] test_dbits5");
      sel = 1; log_n = 0;
      d5_data = 5'h1F; d5_valid = 1'b1;
      step();
      d5_valid = 1'b0;
      checks++;
      if (d5_count !== 3'd1) begin errors++; $display("[TB] FAIL d5_count_push: got %0d expected 1", d5_count); end
      repeat (FRAME5 + 18) step();

      fall = first_low_pin();
      checks++;
      if (fall !== 2) begin errors++; $display("[TB] FAIL d5_fall: got index %0d expected 2", fall); end

      for (int b = 0; b < NB5; b++) begin
         want = exp_bit(9'h01F, 5, 0, b);
         bad = 0; got = want;
         for (int k = 0; k < CYCLE; k++) begin
            if (pin_log[2 + b*CYCLE + k] !== want) begin bad = 1; got = pin_log[2 + b*CYCLE + k]; end
         end
         checks++;
         if (bad != 0) begin errors++; $display("[TB] FAIL d5_bit%0d: got %b expected %b", b, got, want); end
      end

      checks++;
      if (pin_log[1 + FRAME5] !== 1'b1 || pin_log[12] !== 1'b1) begin
         errors++; $display("[TB] FAIL d5_high_bits: got %b %b expected 1 1", pin_log[12], pin_log[1 + FRAME5]);
      end
      drop = first_low_busy();
      checks++;
      if (drop !== 1 + FRAME5) begin errors++; $display("[TB] FAIL d5_busy_drop: got index %0d expected %0d", drop, 1 + FRAME5); end
   endtask

`ifdef UART_TX_PARITY_EN
   // -------------------------------------------------------------------------
   task automatic test_parity();
      int drop, bad;
      $display("[TB] test_parity");
      // Even parity on 0x07 (three ones) gives a parity bit of 1.
      sel = 0; log_n = 0;
      tx_data = 8'h07; tx_data_valid = 1'b1;
      step();
      tx_data_valid = 1'b0;
      repeat (FRAME8 + 18) step();
      bad = 0;
      for (int k = 0; k < CYCLE; k++) if (pin_log[2 + 9*CYCLE + k] !== 1'b1) bad = 1;
      checks++;
      if (bad != 0) begin errors++; $display("[TB] FAIL parity_even_bit: got %b expected 1", pin_log[2 + 9*CYCLE]); end
      drop = first_low_busy();
      checks++;
      if (drop !== 111) begin errors++; $display("[TB] FAIL parity_even_len: got index %0d expected 111", drop); end

      // Odd parity on 0x07 gives a parity bit of 0.
      sel = 2; log_n = 0;
      do_data = 8'h07; do_valid = 1'b1;
      step();
      do_valid = 1'b0;
      repeat (FRAME8 + 18) step();
      bad = 0;
      for (int k = 0; k < CYCLE; k++) if (pin_log[2 + 9*CYCLE + k] !== 1'b0) bad = 1;
      checks++;
      if (bad != 0) begin errors++; $display("[TB] FAIL parity_odd_bit: got %b expected 0", pin_log[2 + 9*CYCLE]); end
      checks++;
      if (pin_log[2 + 10*CYCLE] !== 1'b1 || do_count !== 3'd0 || do_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL parity_odd_stop: got pin=%b count=%0d ready=%b expected 1 0 1",
                            pin_log[2 + 10*CYCLE], do_count, do_ready);
      end
   endtask
`endif

   // -------------------------------------------------------------------------
   initial begin
      errors = 0;
      checks = 0;
      sel    = 0;
      log_n  = 0;
      test_reset();
      test_single();
      test_back_to_back();
      test_full();
      test_reset_mid();
      test_dbits5();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
